// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks the enabled FFT stages in ascending order,
// launches the 64-count stage counter once per stage and waits for its
// end-of-stage pulse. Drives the one-hot stage vector, its binary index and
// the ping-pong bank select for the butterfly datapath.
//
// Optional feature: define FFT_STAGE_SEQ_PERF_EN to add the run_cycles
// output, a saturating count of cycles spent in a run.
module fft_stage_sequencer #(
    parameter int NUM_STAGES = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic                  abort,
    output logic                  cnt_start,
    input  logic                  cnt_new_stage,
    output logic [NUM_STAGES-1:0] stage,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stage_idx,
    output logic                  bank_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
`ifdef FFT_STAGE_SEQ_PERF_EN
    ,
    output logic [15:0]           run_cycles
`endif
);

    localparam int IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // The gap counter is loaded with GAP_CYCLES-1 and leaves GAP at zero.
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_STAGES-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
    logic [IDX_W-1:0]        nxt_q, nxt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    bank_sel_q, bank_sel_d;
    logic                    req_ready_q, req_ready_d;
    logic                    cnt_start_q, cnt_start_d;
    logic [NUM_STAGES-1:0]   stage_q, stage_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;

    logic                    accept;
    logic [IDX_W:0]          first_set;
    logic [IDX_W:0]          next_set;

    // Lowest set bit of m at or above position lo; MSB of the result flags
    // whether any such bit exists.
    function automatic logic [IDX_W:0] find_set(input logic [NUM_STAGES-1:0] m,
                                                input int lo);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                r = {1'b1, IDX_W'(i)};
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic; every output is registered from the
    // value it must take in the state being entered.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        mask_d      = mask_q;
        stage_idx_d = stage_idx_q;
        nxt_d       = nxt_q;
        gap_d       = gap_q;
        bank_sel_d  = bank_sel_q;
        aborted_d   = 1'b0;

        accept    = req_ready_q & req_valid;
        first_set = find_set(stage_en, 0);
        next_set  = find_set(mask_q, int'(stage_idx_q) + 1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mask_d     = stage_en;
                    bank_sel_d = 1'b0;
                    if (first_set[IDX_W]) begin
                        state_d     = S_LAUNCH;
                        stage_idx_d = first_set[IDX_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (cnt_new_stage) begin
                    bank_sel_d = ~bank_sel_q;
                    if (!next_set[IDX_W]) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d     = S_LAUNCH;
                        stage_idx_d = next_set[IDX_W-1:0];
                    end else begin
                        // stage_idx keeps the finished stage through GAP;
                        // the upcoming index waits in nxt_q.
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP_LOAD);
                        nxt_d   = next_set[IDX_W-1:0];
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d     = S_LAUNCH;
                    stage_idx_d = nxt_q;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything else, including a same-cycle end pulse.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            stage_idx_d = '0;
            bank_sel_d  = bank_sel_q;
            aborted_d   = 1'b1;
        end

        cnt_start_d = (state_d == S_LAUNCH);
        stage_d     = ((state_d == S_LAUNCH) || (state_d == S_RUN))
                      ? (NUM_STAGES'(1) << stage_idx_d) : '0;
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            stage_idx_q <= '0;
            nxt_q       <= '0;
            gap_q       <= '0;
            bank_sel_q  <= 1'b0;
            req_ready_q <= 1'b1;
            cnt_start_q <= 1'b0;
            stage_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            mask_q      <= mask_d;
            stage_idx_q <= stage_idx_d;
            nxt_q       <= nxt_d;
            gap_q       <= gap_d;
            bank_sel_q  <= bank_sel_d;
            req_ready_q <= req_ready_d;
            cnt_start_q <= cnt_start_d;
            stage_q     <= stage_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cnt_start = cnt_start_q;
    assign stage     = stage_q;
    assign stage_idx = stage_idx_q;
    assign bank_sel  = bank_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

`ifdef FFT_STAGE_SEQ_PERF_EN
    logic [15:0] run_cycles_q, run_cycles_d;

    // Run length: cleared on accept, counts every busy cycle, saturates.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (accept) begin
            run_cycles_d = '0;
        end else if ((state_q != S_IDLE) && (run_cycles_q != 16'hFFFF)) begin
            run_cycles_d = run_cycles_q + 16'd1;
        end
    end

    // Run-length register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule
